// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - vehicle tail-light sequencer for both lamp banks
//
// Purpose:
//   A free-running divider produces a one-cycle step strobe. On each strobe a
//   mode FSM (IDLE/LEFT/RIGHT/HAZ) picks up the highest-priority request. It
//   then advances a progressive fill on the turning side or toggles the hazard
//   flash phase. Brake lights every bank that is not sequencing, except in
//   hazard mode. Lamp outputs are registered from the next-state view, so
//   they follow state and Brake with one cycle of latency.
//
// Parameters:
//   LAMPS      lamps per side, 1..8
//   DIV_W      divider width, one step every 2^DIV_W clocks
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst        in   asynchronous active-high reset
//   Left_req   in   left turn request, level
//   Right_req  in   right turn request, level
//   Hazard_req in   hazard request, level
//   Brake      in   brake pedal, level
//   Left       out  left lamp bank, bit 0 innermost, registered
//   Right      out  right lamp bank, bit 0 innermost, registered
//   Tick       out  step strobe, one Clk cycle per divider period

module taillight_seq #(
    parameter int LAMPS = 3,
    parameter int DIV_W = 26
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Left_req,
    input  logic             Right_req,
    input  logic             Hazard_req,
    input  logic             Brake,
    output logic [LAMPS-1:0] Left,
    output logic [LAMPS-1:0] Right,
    output logic             Tick
);

    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LAMPS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;
    localparam logic [1:0] ST_HAZ   = 2'd3;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;
    logic [1:0]        req_mode;
    logic [STEP_W-1:0] step_q, step_d;
    logic              phase_q, phase_d;
    logic [LAMPS-1:0]  left_q, left_d;
    logic [LAMPS-1:0]  right_q, right_d;

    logic [LAMPS-1:0]  fill_bank;
    logic [LAMPS-1:0]  haz_bank;
    logic [LAMPS-1:0]  brake_bank;

    // Step k lights the innermost k lamps.
    function automatic logic [LAMPS-1:0] fill_pattern(input logic [STEP_W-1:0] k);
        logic [LAMPS-1:0] v;
        v = '0;
        for (int i = 0; i < LAMPS; i++) begin
            if (i < int'(k)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Divider: strobe while the counter sits at its maximum.
    assign cnt_d = cnt_q + DIV_W'(1);
    assign Tick  = &cnt_q;

    // Both turn requests together are treated as hazard.
    always_comb begin
        req_mode = ST_IDLE;
        if (Hazard_req || (Left_req && Right_req)) begin
            req_mode = ST_HAZ;
        end else if (Left_req) begin
            req_mode = ST_LEFT;
        end else if (Right_req) begin
            req_mode = ST_RIGHT;
        end
    end

    // Mode/step/phase only move on the strobe; requests between strobes
    // are never latched.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        if (Tick) begin
            if (req_mode != state_q) begin
                state_d = req_mode;
                step_d  = '0;
                phase_d = 1'b0;
            end else begin
                case (state_q)
                    ST_LEFT, ST_RIGHT: begin
                        step_d = (step_q == STEP_MAX) ? '0 : step_q + STEP_W'(1);
                    end
                    ST_HAZ: begin
                        phase_d = ~phase_q;
                    end
                    default: begin
                        step_d  = step_q;
                        phase_d = phase_q;
                    end
                endcase
            end
        end
    end

    // Lamp patterns derive from the next state so a mode change shows on the
    // same edge that commits it; Brake is sampled every cycle.
    assign fill_bank  = fill_pattern(step_d);
    assign haz_bank   = {LAMPS{phase_d}};
    assign brake_bank = {LAMPS{Brake}};

    always_comb begin
        left_d  = brake_bank;
        right_d = brake_bank;
        case (state_d)
            ST_LEFT: begin
                left_d  = fill_bank;
                right_d = brake_bank;
            end
            ST_RIGHT: begin
                left_d  = brake_bank;
                right_d = fill_bank;
            end
            ST_HAZ: begin
                left_d  = haz_bank;
                right_d = haz_bank;
            end
            default: begin
                left_d  = brake_bank;
                right_d = brake_bank;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            step_q  <= '0;
            phase_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign Left  = left_q;
    assign Right = right_q;

endmodule

// File: tb/tb_taillight_seq.sv
// tb/tb_taillight_seq.sv - self-checking bench for taillight_seq (LAMPS 1/3/5, DIV_W 3)

module tb_taillight_seq;

    localparam int DIV_W  = 3;
    localparam int PERIOD = 1 << DIV_W;

    localparam int M_IDLE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;
    localparam int M_HAZ   = 3;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic Left_req = 1'b0, Right_req = 1'b0, Hazard_req = 1'b0, Brake = 1'b0;

    logic [0:0] l1_left, l1_right;
    logic [2:0] l3_left, l3_right;
    logic [4:0] l5_left, l5_right;
    logic       t1, t3, t5;

    always #5 Clk = ~Clk;

    taillight_seq #(.LAMPS(1), .DIV_W(DIV_W)) u_l1 (
        .Clk(Clk), .Rst(Rst), .Left_req(Left_req), .Right_req(Right_req),
        .Hazard_req(Hazard_req), .Brake(Brake), .Left(l1_left), .Right(l1_right), .Tick(t1));
    taillight_seq #(.LAMPS(3), .DIV_W(DIV_W)) u_l3 (
        .Clk(Clk), .Rst(Rst), .Left_req(Left_req), .Right_req(Right_req),
        .Hazard_req(Hazard_req), .Brake(Brake), .Left(l3_left), .Right(l3_right), .Tick(t3));
    taillight_seq #(.LAMPS(5), .DIV_W(DIV_W)) u_l5 (
        .Clk(Clk), .Rst(Rst), .Left_req(Left_req), .Right_req(Right_req),
        .Hazard_req(Hazard_req), .Brake(Brake), .Left(l5_left), .Right(l5_right), .Tick(t5));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycle count since reset, and per-instance mode/step/phase.
    int lamps   [3] = '{1, 3, 5};
    int m_mode  [3];
    int m_step  [3];
    int m_phase [3];
    int m_left  [3];
    int m_right [3];
    int m_cycles;

    typedef struct {
        logic lreq;
        logic rreq;
        logic hreq;
        logic brk;
        int   exp_left;
        int   exp_right;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int all_on(input int n);
        return (1 << n) - 1;
    endfunction

    function automatic bit model_tick();
        return (m_cycles % PERIOD) == PERIOD - 1;
    endfunction

    task automatic model_reset();
        m_cycles = 0;
        for (int j = 0; j < 3; j++) begin
            m_mode[j] = M_IDLE; m_step[j] = 0; m_phase[j] = 0;
            m_left[j] = 0; m_right[j] = 0;
        end
    endtask

    task automatic model_step();
        int req;
        int brk_bank;
        if (Hazard_req || (Left_req && Right_req)) req = M_HAZ;
        else if (Left_req)  req = M_LEFT;
        else if (Right_req) req = M_RIGHT;
        else                req = M_IDLE;
        for (int j = 0; j < 3; j++) begin
            if (model_tick()) begin
                if (req != m_mode[j]) begin
                    m_mode[j] = req; m_step[j] = 0; m_phase[j] = 0;
                end else if (m_mode[j] == M_LEFT || m_mode[j] == M_RIGHT) begin
                    m_step[j] = (m_step[j] + 1) % (lamps[j] + 1);
                end else if (m_mode[j] == M_HAZ) begin
                    m_phase[j] = 1 - m_phase[j];
                end
            end
            brk_bank = Brake ? all_on(lamps[j]) : 0;
            case (m_mode[j])
                M_LEFT:  begin m_left[j] = all_on(m_step[j]); m_right[j] = brk_bank; end
                M_RIGHT: begin m_left[j] = brk_bank; m_right[j] = all_on(m_step[j]); end
                M_HAZ:   begin
                    m_left[j]  = m_phase[j] ? all_on(lamps[j]) : 0;
                    m_right[j] = m_left[j];
                end
                default: begin m_left[j] = brk_bank; m_right[j] = brk_bank; end
            endcase
        end
        m_cycles++;
    endtask

    task automatic compare_model();
        int dl [3];
        int dr [3];
        int dt [3];
        dl[0] = int'(l1_left); dr[0] = int'(l1_right); dt[0] = int'(t1);
        dl[1] = int'(l3_left); dr[1] = int'(l3_right); dt[1] = int'(t3);
        dl[2] = int'(l5_left); dr[2] = int'(l5_right); dt[2] = int'(t5);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("model_left_L%0d", lamps[j]),  dl[j], m_left[j]);
            check($sformatf("model_right_L%0d", lamps[j]), dr[j], m_right[j]);
            check($sformatf("model_tick_L%0d", lamps[j]),  dt[j], model_tick() ? 1 : 0);
        end
    endtask

    // One clock: model follows the DUT edge, compare 1 time unit later.
    task automatic cyc();
        @(posedge Clk);
        if (Rst) model_reset();
        else     model_step();
        #1;
        compare_model();
    endtask

    task automatic run_to_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            seen = model_tick();
            cyc();
            if (seen) break;
        end
        if (!seen) check({name, "_tick_timeout"}, 0, 1);
    endtask

    task automatic set_in(input logic l, input logic r, input logic h, input logic b);
        Left_req = l; Right_req = r; Hazard_req = h; Brake = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int exp5 [6] = '{1, 3, 7, 15, 31, 0};
        int exp1 [6] = '{1, 0, 1, 0, 1, 0};

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7, 3};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 7, 7};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 7, 7};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 7};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 7};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 7};

        model_reset();
        #1;
        check("reset_left", int'(l3_left), 0);
        check("reset_right", int'(l3_right), 0);
        check("reset_tick", int'(t3), 0);
        cyc();
        cyc();
        Rst = 1'b0;

        // First tick lands on the 8th cycle after release, then every 8.
        edges = 0;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            cyc();
            if (t3) begin edges = k; break; end
        end
        check("first_tick_edges", edges, PERIOD - 1);
        edges = 0;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            cyc();
            if (t3) begin edges = k; break; end
        end
        check("tick_period", edges, PERIOD);

        // Table: inputs held for a whole period, patterns checked after its tick.
        for (int i = 0; i < 19; i++) begin
            set_in(tbl[i].lreq, tbl[i].rreq, tbl[i].hreq, tbl[i].brk);
            run_to_tick($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_left", i), int'(l3_left), tbl[i].exp_left);
            check($sformatf("tbl%0d_right", i), int'(l3_right), tbl[i].exp_right);
        end

        // Brake edge during a right turn acts within one cycle, off-tick.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        run_to_tick("brk_enter");
        cyc();
        Brake = 1'b1;
        check("brk_before_edge", int'(l3_left), 0);
        cyc();
        check("brk_on_left", int'(l3_left), 7);
        check("brk_on_right", int'(l3_right), 0);
        Brake = 1'b0;
        cyc();
        check("brk_off_left", int'(l3_left), 0);
        run_to_tick("brk_seq");
        check("brk_seq_right", int'(l3_right), 1);

        // Parameter sweep: LAMPS=5 runs 6 ticks per cycle, LAMPS=1 runs 2.
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        run_to_tick("sweep_idle");
        Left_req = 1'b1;
        run_to_tick("sweep_enter");
        check("sweep_enter_l5", int'(l5_left), 0);
        check("sweep_enter_l1", int'(l1_left), 0);
        for (int t = 0; t < 6; t++) begin
            run_to_tick($sformatf("sweep%0d", t));
            check($sformatf("sweep%0d_l5", t), int'(l5_left), exp5[t]);
            check($sformatf("sweep%0d_l1", t), int'(l1_left), exp1[t]);
        end

        // Randomized run against the model, with an asynchronous reset mid-run.
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 11) == 0) Left_req   = ~Left_req;
            if ($urandom_range(0, 11) == 0) Right_req  = ~Right_req;
            if ($urandom_range(0, 29) == 0) Hazard_req = ~Hazard_req;
            if ($urandom_range(0, 7)  == 0) Brake      = ~Brake;
            if (c == 450) begin
                #2;
                Rst = 1'b1;
                #1;
                model_reset();
                check("async_rst_l3_left", int'(l3_left), 0);
                check("async_rst_l5_right", int'(l5_right), 0);
                check("async_rst_tick", int'(t3), 0);
                cyc();
                cyc();
                Rst = 1'b0;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/taillight_seq.md
# taillight_seq

Parametrised vehicle tail-light sequencer driving both lamp banks from one clock domain. An internal divider generates a step tick. A mode FSM arbitrates left-turn, right-turn, hazard and brake requests and produces a progressive fill pattern on the turning side, a synchronous flash for hazard, and steady-on brake lamps on any side not sequencing. It sits between the driver-input debouncers and the lamp output drivers.

## Interface
- LAMPS, default 3: lamps per side, legal range 1..8.
- DIV_W, default 26: tick divider width; one step every 2^DIV_W clocks. Benches use 3.
- Clk  in  1  system clock; all state on rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- Left_req  in  1  left turn request, level, synchronous to Clk.
- Right_req  in  1  right turn request, level.
- Hazard_req  in  1  hazard request, level.
- Brake  in  1  brake pedal, level.
- Left  out  LAMPS  left lamp bank, registered; bit 0 is innermost.
- Right  out  LAMPS  right lamp bank, registered; bit 0 is innermost.
- Tick  out  1  step strobe, high for exactly one Clk cycle per period.

## Operation
- Divider: DIV_W-bit counter, reset 0, increments every cycle and wraps. Tick = (counter == 2^DIV_W-1), decoded combinationally from the register.
- Mode request is evaluated every cycle. Priority, highest first:
  - Hazard_req, or Left_req and Right_req both high: HAZ.
  - Left_req: LEFT.
  - Right_req: RIGHT.
  - Otherwise IDLE.
- FSM states IDLE, LEFT, RIGHT, HAZ. Step counter width clog2(LAMPS+1), range 0..LAMPS. Hazard phase is a 1-bit register.
- State and step change only on cycles with Tick=1:
  - Requested mode differs from current: enter the requested mode, step=0, phase=0.
  - Same mode, LEFT/RIGHT: step = (step==LAMPS) ? 0 : step+1.
  - Same mode, HAZ: phase toggles.
  - Same mode, IDLE: no change.
- Pattern, step k: lowest k bits set on the sequencing side, (1<<k)-1. k=0 is all off. Each cycle is LAMPS+1 ticks long.
- Hazard: both banks all ones when phase=1, all zeros when phase=0.
- Brake is applied every cycle, independent of Tick:
  - Each bank not owned by a sequence shows all ones while Brake=1. In IDLE that is both banks, in LEFT it is Right, in RIGHT it is Left.
  - Brake is ignored in HAZ.
  - Brake never alters the sequencing bank.
- Bank not sequencing and Brake=0: all zeros.
- Outputs are registered from next-state/pattern logic, so they reflect state and Brake with one cycle of latency.
- Request lines are not latched; a request dropped before a tick is never seen.

## Timing
- Reset values: counter 0, state IDLE, step 0, phase 0, Left 0, Right 0. Tick is 0 until the counter reaches its maximum.
- First Tick is the 2^DIV_W-th cycle after Rst deasserts, when the counter is at its maximum. Ticks repeat every 2^DIV_W cycles.
- Mode/step update on the rising edge ending the Tick cycle. Lamps show the new pattern from that edge onward.
- Brake edge to lamp change: 1 cycle, regardless of Tick.
- Request change to mode change: up to 2^DIV_W cycles (next Tick). Multiple request changes between ticks: only the value during the Tick cycle matters.
- Mode switch mid-sequence, for example LEFT step 2 to RIGHT: on that tick Left clears and Right shows step 0. No partial carry-over.
- Rst mid-sequence: all outputs 0 immediately (asynchronous) and the divider restarts. The first Tick after release is again 2^DIV_W cycles later.
- LAMPS=1: sequence alternates off/on, i.e. step 0/1.

## Test plan
- Reset, idle: assert Rst mid-run with DIV_W=3 -> Left=Right=000 immediately. Tick first high 8 cycles after release, then every 8 cycles.
- Left sequence: Left_req=1 held, LAMPS=3 -> Left steps 000,001,011,111,000 on successive ticks. Right stays 000.
- Brake during right turn: Right_req=1, Brake=1 -> Left=111 one cycle after Brake rises and Right keeps sequencing. Brake=0 -> Left=000 one cycle later.
- Hazard and priority: Left_req=Right_req=1 -> both banks alternate 111/000 each tick, starting 000. Brake=1 is ignored. Adding Hazard_req changes nothing.
- Mid-sequence switch: LEFT at step 2 (Left=011), swap to Right_req at the next tick -> Left=000, Right=000. The following tick gives Right=001.
- Parameter sweep: LAMPS=1 and LAMPS=5 -> sequence lengths 2 and 6 ticks, and the final pattern of a full cycle is all ones (1 and 11111).
